trigger_conditioner: RTL and testbench

- Conditions the raw external `trigger_i` from the target and produces a single-cycle qualified fire strobe that enables the pulser.
- Sits between the trigger pin and the pulser `en` input inside glitch_control.
- Provides input synchronisation, a programmable glitch filter, edge/level selection, an arm/disarm state machine with auto-rearm and holdoff, and fire/missed event counters for the UART handler to report.

---
 rtl/trigger_conditioner.sv | 171 +++++++++++++++++
 tb/tb_trigger_conditioner.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_conditioner.sv
// trigger_conditioner: synchronises and filters the raw target trigger,
// detects the selected edge/level, and gates it through an arm/holdoff FSM
// into a single-cycle fire strobe for the pulser. Keeps saturating fire and
// missed-event counters for status reporting.
module trigger_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_W    = 8,
    parameter int HOLDOFF_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trigger_i,
    input  logic                 arm_i,
    input  logic                 disarm_i,
    input  logic [1:0]           edge_sel_i,
    input  logic [FILTER_W-1:0]  filter_len_i,
    input  logic [HOLDOFF_W-1:0] holdoff_i,
    input  logic                 auto_rearm_i,
    input  logic                 pulser_ready_i,
    output logic                 fire_o,
    output logic                 armed_o,
    output logic                 trig_level_o,
    output logic [7:0]           fire_count_o,
    output logic [7:0]           missed_count_o
);

    localparam logic [FILTER_W-1:0]  F_ONE = {{(FILTER_W-1){1'b0}}, 1'b1};
    localparam logic [HOLDOFF_W-1:0] H_ONE = {{(HOLDOFF_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_filt;
    logic                   r_filt_d;
    logic [FILTER_W-1:0]    r_fcnt;
    logic [HOLDOFF_W-1:0]   r_hcnt;
    logic [7:0]             r_fire_cnt;
    logic [7:0]             r_miss_cnt;
    logic                   r_fire;
    state_t                 r_state;

    state_t w_next;
    logic   w_s;
    logic   w_event;
    logic   w_fire_set;
    logic   w_miss;
    logic   w_clr_cnt;
    logic   w_load_hold;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Metastability chain: trigger_i enters at bit 0, last stage is the clean sample
    always_ff @(posedge clk) begin
        if (!rst) r_sync <= '0;
        else      r_sync <= {r_sync[SYNC_STAGES-2:0], trigger_i};
    end

    // Glitch filter: a new level must persist filter_len_i extra cycles; runs in every state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_filt   <= 1'b0;
            r_filt_d <= 1'b0;
            r_fcnt   <= '0;
        end else begin
            r_filt_d <= r_filt;
            if (w_s != r_filt) begin
                if (r_fcnt == filter_len_i) begin
                    r_filt <= w_s;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + F_ONE;
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    // Event qualification from the filtered level and its one-cycle-old copy
    always_comb begin
        w_event = 1'b0;
        case (edge_sel_i)
            2'b00:   w_event = r_filt & ~r_filt_d;
            2'b01:   w_event = ~r_filt & r_filt_d;
            2'b10:   w_event = r_filt ^ r_filt_d;
            default: w_event = r_filt;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // FSM next state and action strobes; disarm overrides everything else
    always_comb begin
        w_next      = r_state;
        w_fire_set  = 1'b0;
        w_miss      = 1'b0;
        w_clr_cnt   = 1'b0;
        w_load_hold = 1'b0;
        if (disarm_i) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (arm_i) begin
                        w_next    = ARMED;
                        w_clr_cnt = 1'b1;
                    end
                end
                ARMED: begin
                    if (w_event) begin
                        if (pulser_ready_i) begin
                            w_fire_set  = 1'b1;
                            w_load_hold = 1'b1;
                            w_next      = auto_rearm_i ? HOLDOFF : IDLE;
                        end else begin
                            w_miss = 1'b1;
                        end
                    end
                end
                HOLDOFF: begin
                    if (r_hcnt == '0) w_next = ARMED;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Holdoff countdown: loaded at fire, counts down to zero while in HOLDOFF
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hcnt <= '0;
        end else if (w_load_hold) begin
            r_hcnt <= holdoff_i;
        end else if (r_state == HOLDOFF && r_hcnt != '0) begin
            r_hcnt <= r_hcnt - H_ONE;
        end
    end

    // Registered fire strobe and saturating event counters (cleared on arm)
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fire     <= 1'b0;
            r_fire_cnt <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_fire <= w_fire_set;
            if (w_clr_cnt) begin
                r_fire_cnt <= '0;
                r_miss_cnt <= '0;
            end else begin
                if (w_fire_set && r_fire_cnt != 8'hFF) r_fire_cnt <= r_fire_cnt + 8'd1;
                if (w_miss && r_miss_cnt != 8'hFF)     r_miss_cnt <= r_miss_cnt + 8'd1;
            end
        end
    end

    assign fire_o         = r_fire;
    assign armed_o        = (r_state == ARMED);
    assign trig_level_o   = r_filt;
    assign fire_count_o   = r_fire_cnt;
    assign missed_count_o = r_miss_cnt;

endmodule

// File: tb/tb_trigger_conditioner.sv
// Directed bench for trigger_conditioner: a table of single-pulse scenarios
// plus hand sequences for holdoff, missed events, disarm, saturation, reset.
module tb_trigger_conditioner;

    logic        clk = 1'b0;
    logic        rst;
    logic        trigger_i;
    logic        arm_i;
    logic        disarm_i;
    logic [1:0]  edge_sel_i;
    logic [7:0]  filter_len_i;
    logic [15:0] holdoff_i;
    logic        auto_rearm_i;
    logic        pulser_ready_i;
    logic        fire_o;
    logic        armed_o;
    logic        trig_level_o;
    logic [7:0]  fire_count_o;
    logic [7:0]  missed_count_o;

    int n_cmp = 0;
    int n_bad = 0;

    trigger_conditioner #(.SYNC_STAGES(2), .FILTER_W(8), .HOLDOFF_W(16)) dut (
        .clk(clk), .rst(rst), .trigger_i(trigger_i), .arm_i(arm_i),
        .disarm_i(disarm_i), .edge_sel_i(edge_sel_i), .filter_len_i(filter_len_i),
        .holdoff_i(holdoff_i), .auto_rearm_i(auto_rearm_i),
        .pulser_ready_i(pulser_ready_i), .fire_o(fire_o), .armed_o(armed_o),
        .trig_level_o(trig_level_o), .fire_count_o(fire_count_o),
        .missed_count_o(missed_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        int         flen;
        int         width;
        int         exp_edge;   // edge after which fire_o is high, -1 = never
    } vec_t;

    vec_t tbl[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        trigger_i = 1'b0; arm_i = 1'b0; disarm_i = 1'b0;
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic arm_now();
        arm_i = 1'b1; tick(); arm_i = 1'b0; tick(); tick();
    endtask

    initial begin
        int first, nf, consec, hit, prev;
        string nm;

        tbl[0] = '{2'b00, 0, 4, 3};
        tbl[1] = '{2'b01, 0, 4, 7};
        tbl[2] = '{2'b10, 0, 4, 3};
        tbl[3] = '{2'b11, 0, 4, 3};
        tbl[4] = '{2'b00, 3, 3, -1};
        tbl[5] = '{2'b00, 3, 6, 6};
        tbl[6] = '{2'b01, 3, 6, 12};
        tbl[7] = '{2'b00, 2, 3, 5};
        tbl[8] = '{2'b00, 2, 2, -1};

        edge_sel_i = 2'b00; filter_len_i = 8'd0; holdoff_i = 16'd0;
        auto_rearm_i = 1'b0; pulser_ready_i = 1'b1;
        do_reset();
        check("rst_fire", fire_o, 0);
        check("rst_armed", armed_o, 0);
        check("rst_level", trig_level_o, 0);
        check("rst_fcnt", fire_count_o, 0);
        check("rst_mcnt", missed_count_o, 0);

        // Table: one trigger pulse per scenario, no auto-rearm
        for (int v = 0; v < 9; v++) begin
            do_reset();
            edge_sel_i = tbl[v].mode; filter_len_i = 8'(tbl[v].flen);
            auto_rearm_i = 1'b0; pulser_ready_i = 1'b1;
            arm_now();
            trigger_i = 1'b1;
            first = -1; nf = 0;
            for (int e = 0; e < 25; e++) begin
                tick();
                if (fire_o) begin
                    nf++;
                    if (first < 0) first = e;
                end
                if (e == tbl[v].width - 1) trigger_i = 1'b0;
            end
            nm = $sformatf("vec%0d", v);
            check({nm, "_edge"}, first, tbl[v].exp_edge);
            check({nm, "_nfire"}, nf, (tbl[v].exp_edge >= 0) ? 1 : 0);
            check({nm, "_fcnt"}, fire_count_o, (tbl[v].exp_edge >= 0) ? 1 : 0);
            check({nm, "_armed"}, armed_o, (tbl[v].exp_edge >= 0) ? 0 : 1);
        end

        // Filter level timing: len 3, 6-cycle pulse, filt high after edges 5..10
        do_reset();
        filter_len_i = 8'd3;
        trigger_i = 1'b1;
        for (int e = 0; e < 15; e++) begin
            tick();
            check($sformatf("flt_level_e%0d", e), trig_level_o, (e >= 5 && e <= 10) ? 1 : 0);
            if (e == 5) trigger_i = 1'b0;
        end

        // Holdoff: either edge, holdoff 10, toggles at 0,5,25,45 -> fires at 3,28,48
        do_reset();
        edge_sel_i = 2'b10; filter_len_i = 8'd0; holdoff_i = 16'd10;
        auto_rearm_i = 1'b1; pulser_ready_i = 1'b1;
        arm_now();
        nf = 0; hit = 0;
        for (int c = 0; c < 60; c++) begin
            if (c == 0 || c == 5 || c == 25 || c == 45) trigger_i = ~trigger_i;
            tick();
            if (fire_o) begin
                nf++;
                if (c == 3 || c == 28 || c == 48) hit++;
            end
            if (c == 10) check("hold_armed_mid", armed_o, 0);
            if (c == 20) check("hold_armed_back", armed_o, 1);
        end
        check("hold_nfire", nf, 3);
        check("hold_fire_edges", hit, 3);
        check("hold_fcnt", fire_count_o, 3);
        check("hold_mcnt", missed_count_o, 0);

        // Missed events while pulser busy, then one fire
        do_reset();
        edge_sel_i = 2'b00; filter_len_i = 8'd0; auto_rearm_i = 1'b0;
        pulser_ready_i = 1'b0;
        arm_now();
        nf = 0;
        for (int p = 0; p < 3; p++) begin
            trigger_i = 1'b1;
            repeat (3) begin tick(); if (fire_o) nf++; end
            trigger_i = 1'b0;
            repeat (3) begin tick(); if (fire_o) nf++; end
        end
        check("miss_nfire", nf, 0);
        check("miss_mcnt", missed_count_o, 3);
        check("miss_armed", armed_o, 1);
        pulser_ready_i = 1'b1;
        trigger_i = 1'b1;
        nf = 0;
        repeat (6) begin tick(); if (fire_o) nf++; end
        check("miss_then_fire", nf, 1);
        check("miss_then_fcnt", fire_count_o, 1);
        check("miss_then_mcnt", missed_count_o, 3);

        // Disarm coincident with a qualified event
        do_reset();
        edge_sel_i = 2'b00; filter_len_i = 8'd0; pulser_ready_i = 1'b1;
        arm_now();
        trigger_i = 1'b1;
        tick(); tick(); tick();
        disarm_i = 1'b1;
        tick();
        disarm_i = 1'b0;
        check("dis_fire", fire_o, 0);
        check("dis_armed", armed_o, 0);
        nf = 0;
        repeat (4) begin tick(); if (fire_o) nf++; end
        check("dis_nfire_after", nf, 0);
        check("dis_fcnt", fire_count_o, 0);
        check("dis_mcnt", missed_count_o, 0);
        arm_i = 1'b1; disarm_i = 1'b1;
        tick();
        arm_i = 1'b0; disarm_i = 1'b0;
        check("armdis_idle", armed_o, 0);

        // Saturation: 300 fires with auto-rearm, holdoff 0
        do_reset();
        edge_sel_i = 2'b10; filter_len_i = 8'd0; holdoff_i = 16'd0;
        auto_rearm_i = 1'b1; pulser_ready_i = 1'b1;
        arm_now();
        nf = 0; consec = 0; prev = 0;
        for (int i = 0; i < 1200; i++) begin
            if (i % 4 == 0) trigger_i = ~trigger_i;
            tick();
            if (fire_o) begin
                nf++;
                if (prev != 0) consec++;
            end
            prev = int'(fire_o);
        end
        check("sat_nfire", nf, 300);
        check("sat_fcnt", fire_count_o, 255);
        check("sat_consec", consec, 0);

        // Reset in the middle of a long holdoff
        holdoff_i = 16'd50;
        trigger_i = ~trigger_i;
        repeat (4) tick();
        check("rh_fired", fire_o, 1);
        repeat (5) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rh_fire", fire_o, 0);
        check("rh_armed", armed_o, 0);
        check("rh_level", trig_level_o, 0);
        check("rh_fcnt", fire_count_o, 0);
        check("rh_mcnt", missed_count_o, 0);
        nf = 0;
        repeat (5) begin tick(); if (fire_o || armed_o) nf++; end
        check("rh_idle_after", nf, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
